// File: rtl/avr_uart_tx_if.sv
`timescale 1ns/1ps
// Write-side handshake of the AVR UART transmitter: byte, strobe and ready.
interface avr_uart_tx_if;
  logic [7:0] data;
  logic       new_data;
  logic       ready;

  modport master (output data, new_data, input ready);
  modport slave  (input data, new_data, output ready);
endinterface

// File: rtl/avr_uart_tx.sv
`timescale 1ns/1ps
// 8N1 UART transmitter toward the AVR Rx pin, throttled by the AVR buffer-full flag.
// AVR_UART_TX_FIFO_EN defined: FIFO_DEPTH-entry FIFO; undefined: single holding register.
module avr_uart_tx #(
  parameter int CLK_PER_BIT = 100,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  avr_uart_tx_if.slave host,
  input  logic         block,
  output logic         tx,
  output logic         busy
);
  localparam int            CW       = $clog2(CLK_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST = CW'(CLK_PER_BIT - 1);

  if (CLK_PER_BIT < 2 || CLK_PER_BIT > 65535 || FIFO_DEPTH < 2 || FIFO_DEPTH > 16 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("avr_uart_tx: illegal CLK_PER_BIT or FIFO_DEPTH");
  end

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q;
  logic [1:0]    blk_sync;
  logic [1:0]    rst_dly;
  logic          tx_q, tx_d, busy_q, ready_q;
  logic          wr, pop, avail, full_d, bit_end;
  logic [7:0]    head;

  assign wr         = host.new_data & ready_q;
  assign bit_end    = (cnt_q == BIT_LAST);
  assign host.ready = ready_q;
  assign tx         = tx_q;
  assign busy       = busy_q;

`ifdef AVR_UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [NW-1:0] count_q, count_d;

  assign avail   = (count_q != '0);
  assign head    = mem[rd_ptr];
  assign count_d = count_q + NW'(wr) - NW'(pop);
  assign full_d  = (count_d == NW'(FIFO_DEPTH));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr)  wr_ptr <= wr_ptr + AW'(1);
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= host.data;
  end
`else
  logic [7:0] hold_q;
  logic       hold_vld;

  assign avail  = hold_vld;
  assign head   = hold_q;
  // A write can only land while the register is empty, so wr and pop never coincide.
  assign full_d = wr | (hold_vld & ~pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q   <= '0;
      hold_vld <= 1'b0;
    end else if (wr) begin
      hold_q   <= host.data;
      hold_vld <= 1'b1;
    end else if (pop) begin
      hold_vld <= 1'b0;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    pop     = 1'b0;
    tx_d    = 1'b1;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (avail && !blk_sync[1]) begin
          pop     = 1'b1;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (bit_end) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        tx_d = shift_q[idx_q];
        if (bit_end) begin
          cnt_d = '0;
          idx_d = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d = '0;
          // Chain straight into the next start bit so back-to-back frames have no gap.
          if (avail && !blk_sync[1]) begin
            pop     = 1'b1;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags the FSM by one cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      blk_sync <= 2'b11;
      rst_dly  <= 2'b00;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      if (pop) shift_q <= head;
      blk_sync <= {blk_sync[0], block};
      rst_dly  <= {rst_dly[0], 1'b1};
      tx_q     <= tx_d;
      busy_q   <= (state_q != IDLE) | avail;
      ready_q  <= rst_dly[1] & ~full_d;
    end
  end
endmodule
